// File: rtl/spec_free_list_ctrl_pkg.sv
// Shared definitions for the speculative physical-register free list.
// Provides the sizing parameters, tag/pointer/count types, a modulo-FL_SIZE
// pointer increment (the list depth is not a power of two) and a small
// popcount helper used for the per-cycle pop and commit counts.
package spec_free_list_ctrl_pkg;

  localparam int DISPATCH_WIDTH    = 4;
  localparam int COMMIT_WIDTH      = 4;
  localparam int SIZE_PHYSICAL     = 128;
  localparam int SIZE_LOGICAL      = 32;
  localparam int SIZE_PHYSICAL_LOG = $clog2(SIZE_PHYSICAL);
  localparam int FL_SIZE           = SIZE_PHYSICAL - SIZE_LOGICAL;
  localparam int FL_SIZE_LOG       = $clog2(FL_SIZE);
  localparam int MAX_LANES         = (DISPATCH_WIDTH > COMMIT_WIDTH) ? DISPATCH_WIDTH : COMMIT_WIDTH;
  localparam int CNT_W             = $clog2(MAX_LANES + 1);

  typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_tag_t;
  typedef logic [FL_SIZE_LOG-1:0]       fl_ptr_t;
  typedef logic [FL_SIZE_LOG:0]         fl_cnt_t;
  typedef logic [CNT_W-1:0]             lane_cnt_t;

  localparam fl_cnt_t FL_SIZE_CNT = fl_cnt_t'(FL_SIZE);

  // Pointer increment by at most MAX_LANES; one conditional subtract is
  // enough because both operands are already below FL_SIZE / MAX_LANES.
  function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input lane_cnt_t n);
    fl_cnt_t s;
    s = fl_cnt_t'(p) + fl_cnt_t'(n);
    if (s >= FL_SIZE_CNT) s = s - FL_SIZE_CNT;
    return s[FL_SIZE_LOG-1:0];
  endfunction

  function automatic lane_cnt_t popcount(input logic [DISPATCH_WIDTH-1:0] v);
    lane_cnt_t s;
    s = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) s = s + lane_cnt_t'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/spec_free_list_ctrl_push_compact.sv
// fl_push_compact: prefix sum over the sparse freed-tag valid vector.
// offset_o[j] is the number of valid lanes below lane j, i.e. the distance
// from the tail at which lane j's tag lands; pushCnt_o is the total.
//   freeValid_i  in   COMMIT_WIDTH            freed tag valid per commit lane
//   offset_o     out  CW x CNT_W              compacted write offset per lane
//   pushCnt_o    out  CNT_W                   number of valid freed tags
module fl_push_compact
  import spec_free_list_ctrl_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0]            freeValid_i,
  output logic [COMMIT_WIDTH-1:0][CNT_W-1:0] offset_o,
  output logic [CNT_W-1:0]                   pushCnt_o
);

  lane_cnt_t run_sum;

  // NOTE: combinational logic uses blocking assignments so the running sum
  // is read back within the same pass; every output gets a value on every
  // path, which is what keeps this block free of latches.
  always_comb begin
    run_sum = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      offset_o[j] = run_sum;
      run_sum     = run_sum + lane_cnt_t'(freeValid_i[j]);
    end
    pushCnt_o = run_sum;
  end

endmodule

// File: rtl/spec_free_list_ctrl.sv
// spec_free_list_ctrl: speculative physical-register free list.
// A circular list of FL_SIZE tags with a speculative head (rename pops),
// a committed head (advanced by committing dests) and a shared tail
// (freed tags pushed at commit). A repair copies the committed head/count
// into the speculative ones in a single cycle.
//   clk              in   clock, all state on posedge
//   reset            in   synchronous, active-high
//   destValid_i      in   DW     per-lane rename pop request
//   stall_i          in   1      back-pressure, suppresses the pop
//   freePhys_o       out  DW x tag  next DW free tags from specHead
//   freeListEmpty_o  out  1      requested pops exceed available tags
//   commitDest_i     in   CW     committing instructions with a valid dest
//   freeValid_i      in   CW     freed tag valid (sparse)
//   freePhys_i       in   CW x tag  freed tags
//   recoverFlag_i    in   1      mispredict/exception repair
//   specCount_o      out  FL_SIZE_LOG+1  tags available to rename
module spec_free_list_ctrl
  import spec_free_list_ctrl_pkg::*;
(
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [DISPATCH_WIDTH-1:0]                           destValid_i,
  input  logic                                                stall_i,
  output logic [DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]    freePhys_o,
  output logic                                                freeListEmpty_o,
  input  logic [COMMIT_WIDTH-1:0]                             commitDest_i,
  input  logic [COMMIT_WIDTH-1:0]                             freeValid_i,
  input  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]      freePhys_i,
  input  logic                                                recoverFlag_i,
  output logic [FL_SIZE_LOG:0]                                specCount_o
);

  phys_tag_t entry_q [FL_SIZE];

  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t arch_head_q, arch_head_d;
  fl_ptr_t tail_q, tail_d;
  fl_cnt_t spec_count_q, spec_count_d;
  fl_cnt_t arch_count_q, arch_count_d;

  logic [COMMIT_WIDTH-1:0][CNT_W-1:0] push_offset;
  lane_cnt_t push_cnt, pop_cnt, cmt_cnt, eff_pop;
  logic      do_pop;

  fl_push_compact u_push_compact (
    .freeValid_i (freeValid_i),
    .offset_o    (push_offset),
    .pushCnt_o   (push_cnt)
  );

  // Read ports: no bypass, so tags pushed this cycle become visible next cycle.
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++)
      freePhys_o[k] = entry_q[ptr_add(spec_head_q, lane_cnt_t'(k))];
  end

  always_comb begin
    pop_cnt         = popcount(destValid_i);
    cmt_cnt         = popcount(commitDest_i);
    // Independent of stall so rename sees a stable empty indication.
    freeListEmpty_o = fl_cnt_t'(pop_cnt) > spec_count_q;
    do_pop          = !stall_i && !freeListEmpty_o && !recoverFlag_i;
    eff_pop         = do_pop ? pop_cnt : '0;

    arch_head_d  = ptr_add(arch_head_q, cmt_cnt);
    arch_count_d = arch_count_q + fl_cnt_t'(push_cnt) - fl_cnt_t'(cmt_cnt);
    tail_d       = ptr_add(tail_q, push_cnt);

    // Repair lands on the post-commit state so a same-cycle commit is kept.
    if (recoverFlag_i) begin
      spec_head_d  = arch_head_d;
      spec_count_d = arch_count_d;
    end else begin
      spec_head_d  = ptr_add(spec_head_q, eff_pop);
      spec_count_d = spec_count_q + fl_cnt_t'(push_cnt) - fl_cnt_t'(eff_pop);
    end
  end

  // NOTE: the tag array is reset because the initial free list must hold the
  // tags not claimed by the architectural map; it is not scratch storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) entry_q[i] <= phys_tag_t'(SIZE_LOGICAL + i);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++)
        if (freeValid_i[j]) entry_q[ptr_add(tail_q, push_offset[j])] <= freePhys_i[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_head_q  <= '0;
      arch_head_q  <= '0;
      tail_q       <= '0;
      spec_count_q <= FL_SIZE_CNT;
      arch_count_q <= FL_SIZE_CNT;
    end else begin
      spec_head_q  <= spec_head_d;
      arch_head_q  <= arch_head_d;
      tail_q       <= tail_d;
      spec_count_q <= spec_count_d;
      arch_count_q <= arch_count_d;
    end
  end

  assign specCount_o = spec_count_q;

`ifndef SYNTHESIS
  fl_cnt_t ptr_gap, in_flight;

  always_comb begin
    ptr_gap   = (spec_head_q >= arch_head_q)
              ? fl_cnt_t'(fl_ptr_t'(spec_head_q - arch_head_q))
              : fl_cnt_t'(spec_head_q) + FL_SIZE_CNT - fl_cnt_t'(arch_head_q);
    in_flight = arch_count_q - spec_count_q;
    if (in_flight == FL_SIZE_CNT) in_flight = '0;
  end

  a_count_order: assert property (@(posedge clk) disable iff (reset)
    spec_count_q <= arch_count_q && arch_count_q <= FL_SIZE_CNT);
  a_ptr_gap: assert property (@(posedge clk) disable iff (reset)
    ptr_gap == in_flight);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    fl_cnt_t'(push_cnt) <= FL_SIZE_CNT - arch_count_q);
  a_commit_bound: assert property (@(posedge clk) disable iff (reset)
    fl_cnt_t'(cmt_cnt) <= arch_count_q - spec_count_q);
`endif

endmodule
